// File: rtl/fifo_pkg.sv
// Shared parameters and helpers for the single-clock FIFO and its drain stages.
// The FIFO and the word packer both take their default widths from here.
package fifo_pkg;

    localparam int ADDR_WIDTH = 4;
    localparam int IN_WIDTH   = 8;
    localparam int PACK       = 4;
    localparam int OUT_WIDTH  = IN_WIDTH * PACK;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Drains bytes from the FIFO and packs PACK of them, little-endian, into one word
// on a valid/ready output; a flush pulse emits whatever partial word is buffered.
module fifo_word_packer #(
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
    parameter int IN_WIDTH   = fifo_pkg::IN_WIDTH,
    parameter int PACK       = fifo_pkg::PACK,
    localparam int OUT_W     = IN_WIDTH * PACK,
    localparam int CNT_W     = fifo_pkg::clog2(PACK + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH:0]   fifo_fillcount,
    input  logic [IN_WIDTH-1:0]   fifo_data,
    output logic                  fifo_get,
    input  logic                  flush,
    output logic [OUT_W-1:0]      out_data,
    output logic [CNT_W-1:0]      out_count,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int LANE_W = fifo_pkg::clog2(PACK);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(PACK);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(PACK - 1);

    logic [CNT_W-1:0]    issued;
    logic [CNT_W-1:0]    landed;
    logic                land_v;
    logic                flush_pend;
    logic [IN_WIDTH-1:0] lanes [PACK];

    logic                slot_free;
    logic                complete;
    logic                held_transfer;
    logic                flush_fire;
    logic [PACK-1:0]     lane_we;
    logic                load_word;
    logic [OUT_W-1:0]    load_data;
    logic [CNT_W-1:0]    load_count;

    // Invariant: issued == landed + land_v, so issued==landed means nothing in flight.
    always_comb begin
        slot_free     = !out_valid || out_ready;
        complete      = land_v && (landed == LAST_C) && slot_free;
        held_transfer = (landed == FULL_C) && slot_free;
        flush_fire    = flush_pend && (issued == landed) && slot_free && !held_transfer;
        fifo_get      = !reset && (fifo_fillcount != '0) && !flush_pend
                        && ((issued < FULL_C) || complete);
        lane_we       = '0;
        if (land_v) begin
            lane_we[landed[LANE_W-1:0]] = 1'b1;
        end
    end

    always_comb begin
        load_word  = 1'b0;
        load_data  = '0;
        load_count = '0;
        if (complete) begin
            load_word  = 1'b1;
            load_count = FULL_C;
            for (int i = 0; i < PACK - 1; i++) begin
                load_data[i*IN_WIDTH +: IN_WIDTH] = lanes[i];
            end
            load_data[(PACK-1)*IN_WIDTH +: IN_WIDTH] = fifo_data;
        end else if (held_transfer) begin
            load_word  = 1'b1;
            load_count = FULL_C;
            for (int i = 0; i < PACK; i++) begin
                load_data[i*IN_WIDTH +: IN_WIDTH] = lanes[i];
            end
        end else if (flush_fire && (landed != '0)) begin
            load_word  = 1'b1;
            load_count = landed;
            for (int i = 0; i < PACK; i++) begin
                if (CNT_W'(i) < landed) begin
                    load_data[i*IN_WIDTH +: IN_WIDTH] = lanes[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PACK; i++) begin
                lanes[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PACK; i++) begin
                if (lane_we[i]) begin
                    lanes[i] <= fifo_data;
                end
            end
        end
    end

    // A completing word may overlap the first get of the next word, hence issued<=1.
    always_ff @(posedge clk) begin
        if (reset) begin
            issued     <= '0;
            landed     <= '0;
            land_v     <= 1'b0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_count  <= '0;
        end else begin
            land_v <= fifo_get;

            if (complete) begin
                issued <= fifo_get ? CNT_W'(1) : '0;
                landed <= '0;
            end else if (held_transfer || flush_fire) begin
                issued <= '0;
                landed <= '0;
            end else begin
                if (fifo_get) begin
                    issued <= issued + CNT_W'(1);
                end
                if (land_v) begin
                    landed <= landed + CNT_W'(1);
                end
            end

            if (flush) begin
                flush_pend <= 1'b1;
            end else if (flush_fire) begin
                flush_pend <= 1'b0;
            end

            if (load_word) begin
                out_data  <= load_data;
                out_count <= load_count;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
